// File: rtl/calculadora_param.sv
// Sequential calculator: add, |A-B|, shift-add multiply and restoring divide on W-bit operands.
// Defining CALCULADORA_SIGN_EN adds output neg, flagging A<B on a subtraction.
module calculadora_param #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     sel,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  output logic [2*W-1:0] result,
  output logic [W-1:0]   resto,
  output logic           busy,
  output logic           done,
  output logic           div_zero
`ifdef CALCULADORA_SIGN_EN
  ,
  output logic           neg
`endif
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIM  = 2'd2
  } state_t;

  state_t         state_r;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic [1:0]     sel_r;
  logic [CW-1:0]  cnt_r;
  logic [2*W-1:0] acc_r;
  logic [2*W-1:0] mcand_r;
  logic [W-1:0]   mplier_r;
  logic [W-1:0]   rem_r;
  logic [W-1:0]   quot_r;

  logic [2*W-1:0] mul_acc_s;
  logic [W:0]     r_shift_s;
  logic [W:0]     diff_s;
  logic           q_bit_s;
  logic [W-1:0]   rem_next_s;
  logic [W-1:0]   quot_next_s;
  logic [W-1:0]   abs_s;
  logic           last_s;
  logic           fin_s;
  logic [2*W-1:0] res_s;
  logic [W-1:0]   rem_out_s;
  logic           dz_s;

  // One iteration step of both datapaths plus the completion decision for the current op.
  always_comb begin
    mul_acc_s   = acc_r + (mplier_r[0] ? mcand_r : {(2*W){1'b0}});
    r_shift_s   = {rem_r, quot_r[W-1]};
    diff_s      = r_shift_s - {1'b0, b_r};
    q_bit_s     = ~diff_s[W];
    rem_next_s  = q_bit_s ? diff_s[W-1:0] : r_shift_s[W-1:0];
    quot_next_s = {quot_r[W-2:0], q_bit_s};
    abs_s       = (a_r >= b_r) ? (a_r - b_r) : (b_r - a_r);
    last_s      = (cnt_r == CW'(W - 1));
    fin_s       = 1'b0;
    res_s       = {(2*W){1'b0}};
    rem_out_s   = {W{1'b0}};
    dz_s        = 1'b0;
    case (sel_r)
      2'b00: begin
        fin_s = 1'b1;
        res_s = {{W{1'b0}}, a_r} + {{W{1'b0}}, b_r};
      end
      2'b01: begin
        fin_s = 1'b1;
        res_s = {{W{1'b0}}, abs_s};
      end
      2'b10: begin
        if (last_s) begin
          fin_s = 1'b1;
          res_s = mul_acc_s;
        end else begin
          fin_s = 1'b0;
        end
      end
      2'b11: begin
        if (b_r == {W{1'b0}}) begin
          fin_s = 1'b1;
          dz_s  = 1'b1;
        end else if (last_s) begin
          fin_s     = 1'b1;
          res_s     = {{W{1'b0}}, quot_next_s};
          rem_out_s = rem_next_s;
        end else begin
          fin_s = 1'b0;
        end
      end
      default: fin_s = 1'b1;
    endcase
  end

  // Control FSM with registered outputs; datapath registers only advance while in CALC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      a_r      <= {W{1'b0}};
      b_r      <= {W{1'b0}};
      sel_r    <= 2'b00;
      cnt_r    <= {CW{1'b0}};
      acc_r    <= {(2*W){1'b0}};
      mcand_r  <= {(2*W){1'b0}};
      mplier_r <= {W{1'b0}};
      rem_r    <= {W{1'b0}};
      quot_r   <= {W{1'b0}};
      result   <= {(2*W){1'b0}};
      resto    <= {W{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
`ifdef CALCULADORA_SIGN_EN
      neg      <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r      <= A;
            b_r      <= B;
            sel_r    <= sel;
            cnt_r    <= {CW{1'b0}};
            acc_r    <= {(2*W){1'b0}};
            mcand_r  <= {{W{1'b0}}, A};
            mplier_r <= B;
            rem_r    <= {W{1'b0}};
            quot_r   <= A;
            div_zero <= 1'b0;
            busy     <= 1'b1;
            state_r  <= CALC;
          end else begin
            state_r  <= IDLE;
          end
        end
        CALC: begin
          if (fin_s) begin
            result   <= res_s;
            resto    <= rem_out_s;
            div_zero <= dz_s;
`ifdef CALCULADORA_SIGN_EN
            neg      <= (sel_r == 2'b01) && (a_r < b_r);
`endif
            busy     <= 1'b0;
            done     <= 1'b1;
            state_r  <= FIM;
          end else begin
            cnt_r    <= cnt_r + CW'(1);
            acc_r    <= mul_acc_s;
            mcand_r  <= {mcand_r[2*W-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[W-1:1]};
            rem_r    <= rem_next_s;
            quot_r   <= quot_next_s;
          end
        end
        FIM: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calculadora_param.sv
// Randomized self-checking bench for calculadora_param (W=4) against an arithmetic reference model.
module tb_calculadora_param;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [1:0]     sel = 2'b00;
  logic [W-1:0]   A = '0;
  logic [W-1:0]   B = '0;
  logic [2*W-1:0] result;
  logic [W-1:0]   resto;
  logic           busy;
  logic           done;
  logic           div_zero;
`ifdef CALCULADORA_SIGN_EN
  logic           neg;
`endif

  int n_pass = 0;
  int n_total = 0;

  int             cap_lat, cap_busybad;
  logic           cap_busy0, cap_busy, cap_done2, cap_dz, cap_dz2, cap_neg;
  logic [2*W-1:0] cap_res;
  logic [W-1:0]   cap_rem;

  calculadora_param #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel), .A(A), .B(B),
    .result(result), .resto(resto), .busy(busy), .done(done), .div_zero(div_zero)
`ifdef CALCULADORA_SIGN_EN
    , .neg(neg)
`endif
  );

  always #5 clk = ~clk;

  // Reference model straight from the arithmetic definitions.
  function automatic void model(input int a, input int b, input int s,
                                output int res, output int rem, output int dz,
                                output int lat, output int ng);
    res = 0; rem = 0; dz = 0; lat = 1; ng = 0;
    case (s)
      0: res = a + b;
      1: begin res = (a > b) ? a - b : b - a; ng = (a < b) ? 1 : 0; end
      2: begin res = a * b; lat = W; end
      default: begin
        if (b == 0) dz = 1;
        else begin res = a / b; rem = a % b; lat = W; end
      end
    endcase
  endfunction

  // Drive one operation, measure latency to done and capture outputs around completion.
  task automatic issue(input int a, input int b, input int s, input bit hold);
    bit got;
    @(negedge clk);
    A = W'(a); B = W'(b); sel = 2'(s); start = 1'b1;
    @(negedge clk);
    cap_busy0 = busy;
    if (!hold) start = 1'b0;
    A = W'($urandom); B = W'($urandom); sel = 2'($urandom);
    cap_lat = 0; cap_busybad = 0; got = 1'b0;
    while (!got && cap_lat < 40) begin
      @(negedge clk);
      cap_lat++;
      if (done) got = 1'b1;
      else if (!busy) cap_busybad++;
      if (hold) begin A = W'($urandom); B = W'($urandom); end
    end
    if (!got) cap_lat = -1;
    cap_res = result; cap_rem = resto; cap_dz = div_zero; cap_busy = busy;
`ifdef CALCULADORA_SIGN_EN
    cap_neg = neg;
`else
    cap_neg = 1'b0;
`endif
    start = 1'b0;
    @(negedge clk);
    cap_done2 = done; cap_dz2 = div_zero;
  endtask

  task automatic test_reset();
    #12;
    n_total++;
    if (result !== '0 || resto !== '0) $display("FAIL reset_data result=%0d resto=%0d expected 0/0", result, resto);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) $display("FAIL reset_flags busy=%b done=%b dz=%b expected 000", busy, done, div_zero);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_add();
    issue(15, 15, 0, 1'b0);
    n_total++;
    if (cap_lat !== 1) $display("FAIL add_latency got=%0d expected 1", cap_lat); else n_pass++;
    n_total++;
    if (cap_res !== 8'd30 || cap_rem !== 4'd0) $display("FAIL add_result got=%0d/%0d expected 30/0", cap_res, cap_rem); else n_pass++;
    n_total++;
    if (cap_busy0 !== 1'b1 || cap_busy !== 1'b0 || cap_done2 !== 1'b0) $display("FAIL add_handshake busy0=%b busy_done=%b done_next=%b expected 1,0,0", cap_busy0, cap_busy, cap_done2); else n_pass++;
  endtask

  task automatic test_mul();
    issue(9, 7, 2, 1'b0);
    n_total++;
    if (cap_lat !== 4 || cap_busybad !== 0) $display("FAIL mul_timing lat=%0d busy_drops=%0d expected 4/0", cap_lat, cap_busybad); else n_pass++;
    n_total++;
    if (cap_res !== 8'd63) $display("FAIL mul_result got=%0d expected 63", cap_res); else n_pass++;
  endtask

  task automatic test_div();
    issue(13, 4, 3, 1'b0);
    n_total++;
    if (cap_lat !== 4) $display("FAIL div_latency got=%0d expected 4", cap_lat); else n_pass++;
    n_total++;
    if (cap_res !== 8'd3 || cap_rem !== 4'd1 || cap_dz !== 1'b0) $display("FAIL div_result got=%0d r%0d dz=%b expected 3 r1 dz=0", cap_res, cap_rem, cap_dz); else n_pass++;
    issue(5, 0, 3, 1'b0);
    n_total++;
    if (cap_lat !== 1) $display("FAIL divzero_latency got=%0d expected 1", cap_lat); else n_pass++;
    n_total++;
    if (cap_res !== 8'd0 || cap_rem !== 4'd0 || cap_dz !== 1'b1 || cap_dz2 !== 1'b1) $display("FAIL divzero_result got=%0d r%0d dz=%b held=%b expected 0 r0 1 1", cap_res, cap_rem, cap_dz, cap_dz2); else n_pass++;
    issue(2, 3, 0, 1'b0);
    n_total++;
    if (cap_dz !== 1'b0 || cap_res !== 8'd5) $display("FAIL divzero_clear dz=%b result=%0d expected 0/5", cap_dz, cap_res); else n_pass++;
  endtask

  task automatic test_sub();
    issue(3, 9, 1, 1'b0);
    n_total++;
    if (cap_res !== 8'd6 || cap_lat !== 1 || cap_rem !== 4'd0) $display("FAIL sub_a_lt_b got=%0d lat=%0d r%0d expected 6 lat=1 r0", cap_res, cap_lat, cap_rem); else n_pass++;
`ifdef CALCULADORA_SIGN_EN
    n_total++;
    if (cap_neg !== 1'b1) $display("FAIL sub_neg_set got=%b expected 1", cap_neg); else n_pass++;
`endif
    issue(9, 3, 1, 1'b0);
    n_total++;
    if (cap_res !== 8'd6) $display("FAIL sub_a_gt_b got=%0d expected 6", cap_res); else n_pass++;
`ifdef CALCULADORA_SIGN_EN
    n_total++;
    if (cap_neg !== 1'b0) $display("FAIL sub_neg_clr got=%b expected 0", cap_neg); else n_pass++;
`endif
  endtask

  task automatic test_robust();
    issue(9, 7, 2, 1'b1);
    n_total++;
    if (cap_res !== 8'd63 || cap_lat !== 4) $display("FAIL robust_mul got=%0d lat=%0d expected 63 lat=4", cap_res, cap_lat); else n_pass++;
    n_total++;
    if (cap_done2 !== 1'b0 || cap_busybad !== 0) $display("FAIL robust_single_done done_next=%b busy_drops=%0d expected 0/0", cap_done2, cap_busybad); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int k;
    @(negedge clk);
    A = 4'd2; B = 4'd3; sel = 2'b00; start = 1'b1;
    k = 0;
    while (done !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL b2b_fim_ignored busy=%b done=%b expected 0/0", busy, done); else n_pass++;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b1) $display("FAIL b2b_idle_accept busy=%b expected 1", busy); else n_pass++;
    @(negedge clk);
    start = 1'b0;
    n_total++;
    if (done !== 1'b1 || result !== 8'd5) $display("FAIL b2b_second_done done=%b result=%0d expected 1/5", done, result); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int dones;
    issue(5, 6, 0, 1'b0);
    @(negedge clk);
    A = 4'd13; B = 4'd4; sel = 2'b11; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    n_total++;
    if (result !== '0 || resto !== '0 || busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) $display("FAIL midreset_async result=%0d resto=%0d busy=%b done=%b dz=%b expected all 0", result, resto, busy, done, div_zero); else n_pass++;
    @(negedge clk); @(negedge clk); rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (done || busy) dones++; end
    n_total++;
    if (dones !== 0 || result !== '0) $display("FAIL midreset_abort activity=%0d result=%0d expected 0/0", dones, result); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; A = 4'd1; B = 4'd2; sel = 2'b00; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    n_total++;
    if (done !== 1'b1 || result !== 8'd3) $display("FAIL midreset_first_accept done=%b result=%0d expected 1/3", done, result); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_random();
    int a, b, s, eres, erem, edz, elat, eng;
    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(15, 0);
      b = ($urandom_range(7, 0) == 0) ? 0 : $urandom_range(15, 0);
      s = $urandom_range(3, 0);
      model(a, b, s, eres, erem, edz, elat, eng);
      issue(a, b, s, 1'($urandom_range(1, 0)));
      n_total++;
      if (cap_res !== 8'(eres) || cap_rem !== 4'(erem)) $display("FAIL rand_value a=%0d b=%0d sel=%0d got=%0d r%0d expected %0d r%0d", a, b, s, cap_res, cap_rem, eres, erem); else n_pass++;
      n_total++;
      if (cap_lat !== elat || cap_dz !== 1'(edz) || cap_done2 !== 1'b0) $display("FAIL rand_ctrl a=%0d b=%0d sel=%0d lat=%0d dz=%b done_next=%b expected lat=%0d dz=%0d 0", a, b, s, cap_lat, cap_dz, cap_done2, elat, edz); else n_pass++;
`ifdef CALCULADORA_SIGN_EN
      n_total++;
      if (cap_neg !== 1'(eng)) $display("FAIL rand_neg a=%0d b=%0d sel=%0d got=%b expected %0d", a, b, s, cap_neg, eng); else n_pass++;
`endif
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_sub();
    test_robust();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
